// File: rtl/vx_ti_stamp_arb.sv
// Round-robin, burst-locked arbiter merging NUM_REQS tile-interp stamp streams onto one stamp bus.
// Optional performance counters are built when TI_STAMP_ARB_PERF_EN is defined.
module vx_ti_stamp_arb #(
    parameter int  NUM_REQS   = 4,
    parameter int  NUM_LANES  = 4,
    parameter int  STAMP_BITS = 64,
    parameter int  OUT_BUF    = 1,
    localparam int DATA_W     = NUM_LANES * STAMP_BITS + 1,
    localparam int REQ_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQS-1:0]        req_valid_in,
    input  logic [NUM_REQS*DATA_W-1:0] req_data_in,
    output logic [NUM_REQS-1:0]        req_ready_in,
    output logic                       req_valid_out,
    output logic [DATA_W-1:0]          req_data_out,
    output logic [REQ_W-1:0]           req_sel_out,
    input  logic                       req_ready_out
`ifdef TI_STAMP_ARB_PERF_EN
    ,
    output logic [43:0]                perf_stall_cycles,
    output logic [43:0]                perf_bursts
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   lock_idx;

    logic [REQ_W-1:0]   win_idx;
    logic               win_found;
    logic [DATA_W-1:0]  win_data;
    logic               win_done;
    logic               in_ready;
    logic               in_fire;
    logic [REQ_W:0]     scan_sum;

    function automatic logic [REQ_W-1:0] next_idx(input logic [REQ_W-1:0] idx);
        if (int'(idx) >= NUM_REQS - 1)
            return '0;
        else
            return idx + REQ_W'(1);
    endfunction

    // Winner selection: the locked stream only, or the first valid stream at/after rr_ptr.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_sum  = '0;
        if (state == LOCKED) begin
            win_idx   = lock_idx;
            win_found = req_valid_in[lock_idx];
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                scan_sum = {1'b0, rr_ptr} + (REQ_W+1)'(i);
                if (scan_sum >= (REQ_W+1)'(NUM_REQS))
                    scan_sum = scan_sum - (REQ_W+1)'(NUM_REQS);
                if (!win_found && req_valid_in[scan_sum[REQ_W-1:0]]) begin
                    win_idx   = scan_sum[REQ_W-1:0];
                    win_found = 1'b1;
                end
            end
        end
    end

    assign win_data = req_data_in[int'(win_idx) * DATA_W +: DATA_W];
    assign win_done = win_data[0];
    assign in_fire  = win_found & in_ready & ~reset;

    always_comb begin
        req_ready_in = '0;
        if (!reset && win_found)
            req_ready_in[win_idx] = in_ready;
    end

    // Grant stays on a stream from its first accepted beat until its done beat is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else if (in_fire) begin
            if (state == IDLE) begin
                if (win_done) begin
                    rr_ptr <= next_idx(win_idx);
                end else begin
                    lock_idx <= win_idx;
                    state    <= LOCKED;
                end
            end else if (win_done) begin
                state  <= IDLE;
                rr_ptr <= next_idx(lock_idx);
            end
        end
    end

    generate
        if (OUT_BUF != 0) begin : g_skid
            logic              out_valid;
            logic [DATA_W-1:0] out_data;
            logic [REQ_W-1:0]  out_sel;
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [REQ_W-1:0]  skid_sel;

            // Main slot drives the bus; the skid slot catches the beat accepted while stalled.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid  <= 1'b0;
                    out_data   <= '0;
                    out_sel    <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    skid_sel   <= '0;
                end else if (!out_valid || req_ready_out) begin
                    if (skid_valid) begin
                        out_valid  <= 1'b1;
                        out_data   <= skid_data;
                        out_sel    <= skid_sel;
                        skid_valid <= 1'b0;
                    end else begin
                        out_valid <= in_fire;
                        if (in_fire) begin
                            out_data <= win_data;
                            out_sel  <= win_idx;
                        end
                    end
                end else if (in_fire) begin
                    skid_valid <= 1'b1;
                    skid_data  <= win_data;
                    skid_sel   <= win_idx;
                end
            end

            assign in_ready      = ~skid_valid;
            assign req_valid_out = out_valid & ~reset;
            assign req_data_out  = reset ? '0 : out_data;
            assign req_sel_out   = reset ? '0 : out_sel;
        end else begin : g_pass
            assign in_ready      = req_ready_out;
            assign req_valid_out = win_found & ~reset;
            assign req_data_out  = reset ? '0 : win_data;
            assign req_sel_out   = reset ? '0 : win_idx;
        end
    endgenerate

`ifdef TI_STAMP_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_bursts       <= '0;
        end else begin
            if (req_valid_out && !req_ready_out)
                perf_stall_cycles <= perf_stall_cycles + 44'd1;
            if (in_fire && win_done)
                perf_bursts <= perf_bursts + 44'd1;
        end
    end
`endif

`ifndef SYNTHESIS
    // A stalled locked producer must keep its beat steady until it is taken.
    locked_data_stable : assert property (
        @(posedge clk) disable iff (reset)
        (state == LOCKED && req_valid_in[lock_idx] && !req_ready_in[lock_idx])
        |=> $stable(win_data)
    );
`endif

endmodule

// File: tb/tb_vx_ti_stamp_arb.sv
// Directed bench for vx_ti_stamp_arb: round-robin order, burst locking, bubbles, skid stall and reset.
`timescale 1ns/1ps
module tb_vx_ti_stamp_arb;

    localparam int NUM_REQS   = 4;
    localparam int NUM_LANES  = 4;
    localparam int STAMP_BITS = 64;
    localparam int DATA_W     = NUM_LANES * STAMP_BITS + 1;
    localparam int REQ_W      = 2;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [NUM_REQS-1:0]        req_valid_in = '0;
    logic [NUM_REQS*DATA_W-1:0] req_data_in = '0;
    logic [NUM_REQS-1:0]        req_ready_in;
    logic                       req_valid_out;
    logic [DATA_W-1:0]          req_data_out;
    logic [REQ_W-1:0]           req_sel_out;
    logic                       req_ready_out = 1'b1;
`ifdef TI_STAMP_ARB_PERF_EN
    logic [43:0]                perf_stall_cycles;
    logic [43:0]                perf_bursts;
`endif

    int total = 0;
    int bad   = 0;

    vx_ti_stamp_arb #(
        .NUM_REQS   (NUM_REQS),
        .NUM_LANES  (NUM_LANES),
        .STAMP_BITS (STAMP_BITS),
        .OUT_BUF    (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid_in      (req_valid_in),
        .req_data_in       (req_data_in),
        .req_ready_in      (req_ready_in),
        .req_valid_out     (req_valid_out),
        .req_data_out      (req_data_out),
        .req_sel_out       (req_sel_out),
        .req_ready_out     (req_ready_out)
`ifdef TI_STAMP_ARB_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_bursts       (perf_bursts)
`endif
    );

    always #5 clk = ~clk;

    // Every beat carries its source id and sequence number in each 32-bit word.
    function automatic logic [DATA_W-1:0] mk(input int id, input int seq, input logic done);
        logic [DATA_W-1:0] d;
        d    = '0;
        d[0] = done;
        for (int k = 0; k < (DATA_W - 1) / 32; k++)
            d[1 + 32*k +: 32] = {8'(id), 8'(seq), 8'(k), 8'h5a};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic v, input logic [DATA_W-1:0] beat);
        req_valid_in[idx]                  = v;
        req_data_in[idx*DATA_W +: DATA_W]  = beat;
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [REQ_W-1:0] es,
                               input logic [DATA_W-1:0] ed, input logic [NUM_REQS-1:0] er);
        #2;
        total++;
        assert (req_valid_out === ev) else begin
            bad++;
            $error("[TB] FAIL %s.valid observed=%0b expected=%0b", tag, req_valid_out, ev);
        end
        total++;
        assert (req_ready_in === er) else begin
            bad++;
            $error("[TB] FAIL %s.ready_in observed=%b expected=%b", tag, req_ready_in, er);
        end
        if (ev) begin
            total++;
            assert (req_sel_out === es) else begin
                bad++;
                $error("[TB] FAIL %s.sel observed=%0d expected=%0d", tag, req_sel_out, es);
            end
            total++;
            assert (req_data_out === ed) else begin
                bad++;
                $error("[TB] FAIL %s.data observed=%h expected=%h", tag, req_data_out, ed);
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting directed sequence");
        for (int i = 0; i < NUM_REQS; i++)
            applyStimulus(i, 1'b1, mk(i, 0, 1'b0));
        tick();
        tick();
        checkOutput("reset", 1'b0, 2'd0, '0, 4'b0000);
        checkValue("reset.data", req_data_out, '0);
        checkValue("reset.sel", DATA_W'(req_sel_out), '0);

        // Two single-beat bursts at once, then wrap-around from rr_ptr=3
        tick();
        reset = 1'b0;
        applyStimulus(0, 1'b1, mk(0, 1, 1'b1));
        applyStimulus(1, 1'b0, '0);
        applyStimulus(2, 1'b1, mk(2, 1, 1'b1));
        applyStimulus(3, 1'b0, '0);
        checkOutput("t1.arb", 1'b0, 2'd0, '0, 4'b0001);
`ifdef TI_STAMP_ARB_PERF_EN
        checkValue("perf.reset_bursts", DATA_W'(perf_bursts), '0);
        checkValue("perf.reset_stalls", DATA_W'(perf_stall_cycles), '0);
`endif
        tick();
        applyStimulus(0, 1'b0, '0);
        checkOutput("t1.sel0", 1'b1, 2'd0, mk(0, 1, 1'b1), 4'b0100);
        tick();
        applyStimulus(2, 1'b0, '0);
        applyStimulus(0, 1'b1, mk(0, 2, 1'b1));
        applyStimulus(3, 1'b1, mk(3, 1, 1'b1));
        checkOutput("t1.sel2", 1'b1, 2'd2, mk(2, 1, 1'b1), 4'b1000);
        tick();
        applyStimulus(3, 1'b0, '0);
        checkOutput("t1.rr3", 1'b1, 2'd3, mk(3, 1, 1'b1), 4'b0001);
        tick();
        applyStimulus(0, 1'b1, mk(0, 3, 1'b1));
        applyStimulus(1, 1'b1, mk(1, 1, 1'b0));
        checkOutput("t1.wrap", 1'b1, 2'd0, mk(0, 2, 1'b1), 4'b0010);

        // Req1 3-beat burst while req0 waits
        tick();
        applyStimulus(1, 1'b1, mk(1, 2, 1'b0));
        checkOutput("t2.b0", 1'b1, 2'd1, mk(1, 1, 1'b0), 4'b0010);
        tick();
        applyStimulus(1, 1'b1, mk(1, 3, 1'b1));
        checkOutput("t2.b1", 1'b1, 2'd1, mk(1, 2, 1'b0), 4'b0010);
        tick();
        applyStimulus(1, 1'b0, '0);
        checkOutput("t2.b2", 1'b1, 2'd1, mk(1, 3, 1'b1), 4'b0001);
        tick();
        applyStimulus(0, 1'b0, '0);
        checkOutput("t2.req0", 1'b1, 2'd0, mk(0, 3, 1'b1), 4'b0000);

        // Locked req1 bubbles for two cycles while req3 waits
        tick();
        applyStimulus(1, 1'b1, mk(1, 4, 1'b0));
        applyStimulus(3, 1'b1, mk(3, 2, 1'b1));
        checkOutput("t3.start", 1'b0, 2'd0, '0, 4'b0010);
        tick();
        applyStimulus(1, 1'b0, '0);
        checkOutput("t3.c0", 1'b1, 2'd1, mk(1, 4, 1'b0), 4'b0000);
        tick();
        checkOutput("t3.bubble1", 1'b0, 2'd0, '0, 4'b0000);
        tick();
        applyStimulus(1, 1'b1, mk(1, 5, 1'b1));
        checkOutput("t3.bubble2", 1'b0, 2'd0, '0, 4'b0010);
        tick();
        applyStimulus(1, 1'b0, '0);
        checkOutput("t3.c1", 1'b1, 2'd1, mk(1, 5, 1'b1), 4'b1000);
        tick();
        applyStimulus(3, 1'b0, '0);
        checkOutput("t3.req3", 1'b1, 2'd3, mk(3, 2, 1'b1), 4'b0000);

        // Downstream stalled for 5 cycles: only two beats get in, output holds
        tick();
        req_ready_out = 1'b0;
        applyStimulus(2, 1'b1, mk(2, 2, 1'b0));
        checkOutput("t4.start", 1'b0, 2'd0, '0, 4'b0100);
        tick();
        applyStimulus(2, 1'b1, mk(2, 3, 1'b0));
        checkOutput("t4.hold1", 1'b1, 2'd2, mk(2, 2, 1'b0), 4'b0100);
        tick();
        applyStimulus(2, 1'b1, mk(2, 4, 1'b0));
        checkOutput("t4.hold2", 1'b1, 2'd2, mk(2, 2, 1'b0), 4'b0000);
        tick();
        checkOutput("t4.hold3", 1'b1, 2'd2, mk(2, 2, 1'b0), 4'b0000);
        tick();
        checkOutput("t4.hold4", 1'b1, 2'd2, mk(2, 2, 1'b0), 4'b0000);
        tick();
        req_ready_out = 1'b1;
        checkOutput("t4.hold5", 1'b1, 2'd2, mk(2, 2, 1'b0), 4'b0000);
        tick();
        checkOutput("t4.drain1", 1'b1, 2'd2, mk(2, 3, 1'b0), 4'b0100);
        tick();
        applyStimulus(2, 1'b1, mk(2, 5, 1'b1));
        checkOutput("t4.drain2", 1'b1, 2'd2, mk(2, 4, 1'b0), 4'b0100);
        tick();
        applyStimulus(2, 1'b0, '0);
        applyStimulus(1, 1'b1, mk(1, 6, 1'b1));
        checkOutput("t4.drain3", 1'b1, 2'd2, mk(2, 5, 1'b1), 4'b0010);
        tick();
        applyStimulus(1, 1'b0, '0);
        checkOutput("t4.extra", 1'b1, 2'd1, mk(1, 6, 1'b1), 4'b0000);
        tick();
        checkOutput("t4.idle", 1'b0, 2'd0, '0, 4'b0000);
`ifdef TI_STAMP_ARB_PERF_EN
        checkValue("perf.bursts", DATA_W'(perf_bursts), DATA_W'(10));
        checkValue("perf.stalls", DATA_W'(perf_stall_cycles), DATA_W'(4));
`endif

        // Reset in the middle of a req2 burst
        tick();
        applyStimulus(2, 1'b1, mk(2, 6, 1'b0));
        checkOutput("t5.start", 1'b0, 2'd0, '0, 4'b0100);
        tick();
        applyStimulus(2, 1'b1, mk(2, 7, 1'b0));
        checkOutput("t5.e0", 1'b1, 2'd2, mk(2, 6, 1'b0), 4'b0100);
        tick();
        reset = 1'b1;
        applyStimulus(2, 1'b1, mk(2, 8, 1'b0));
        checkOutput("t5.inreset", 1'b0, 2'd0, '0, 4'b0000);
        checkValue("t5.inreset.data", req_data_out, '0);
        tick();
        reset = 1'b0;
        applyStimulus(0, 1'b1, mk(0, 9, 1'b1));
        applyStimulus(2, 1'b1, mk(2, 9, 1'b1));
        checkOutput("t5.after", 1'b0, 2'd0, '0, 4'b0001);
`ifdef TI_STAMP_ARB_PERF_EN
        checkValue("perf.cleared_bursts", DATA_W'(perf_bursts), '0);
        checkValue("perf.cleared_stalls", DATA_W'(perf_stall_cycles), '0);
`endif
        tick();
        applyStimulus(0, 1'b0, '0);
        checkOutput("t5.req0", 1'b1, 2'd0, mk(0, 9, 1'b1), 4'b0100);
        tick();
        applyStimulus(2, 1'b0, '0);
        checkOutput("t5.req2", 1'b1, 2'd2, mk(2, 9, 1'b1), 4'b0000);
        tick();
        checkOutput("t5.idle", 1'b0, 2'd0, '0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
